// File: rtl/exu_oitf.sv
// exu_oitf: outstanding instruction track FIFO for long-pipe (load/store) instructions
// Ports: clk, rst (async active-high)
//   dispatch   : dis_ena, dis_ready, dis_rdwen, dis_rdidx, dis_ptr
//   hazard     : disp_rs1idx/rs2idx, disp_rs1en/rs2en -> oitfrd_match_rs1/rs2/rd
//   retire     : oitf_ret_ena, oitf_ret_ptr, oitf_ret_rdwen, oitf_ret_rdidx, oitf_empty
// Option: define OITF_FULL_BYPASS_EN to let a full FIFO accept an allocation into
//   the slot freed by a same-cycle retire.
`ifndef ITAG_WIDTH
`define ITAG_WIDTH 2
`endif
`ifndef RFIDX_WIDTH
`define RFIDX_WIDTH 5
`endif
module exu_oitf #(
   parameter int OITF_DEPTH = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    dis_ena,
   output logic                    dis_ready,
   input  logic                    dis_rdwen,
   input  logic [`RFIDX_WIDTH-1:0] dis_rdidx,
   output logic [`ITAG_WIDTH-1:0]  dis_ptr,
   input  logic [`RFIDX_WIDTH-1:0] disp_rs1idx,
   input  logic [`RFIDX_WIDTH-1:0] disp_rs2idx,
   input  logic                    disp_rs1en,
   input  logic                    disp_rs2en,
   output logic                    oitfrd_match_rs1,
   output logic                    oitfrd_match_rs2,
   output logic                    oitfrd_match_rd,
   input  logic                    oitf_ret_ena,
   output logic [`ITAG_WIDTH-1:0]  oitf_ret_ptr,
   output logic                    oitf_ret_rdwen,
   output logic [`RFIDX_WIDTH-1:0] oitf_ret_rdidx,
   output logic                    oitf_empty
);
   localparam int AW = `ITAG_WIDTH;
   localparam int RW = `RFIDX_WIDTH;
   logic [OITF_DEPTH-1:0] vld, rdwen;
   logic [RW-1:0]         rdidx [OITF_DEPTH];
   logic [AW-1:0]         alloc_ptr, ret_ptr;
   logic                  alloc_flg, ret_flg;
   logic                  full, alloc_fire, ret_fire, alloc_last, ret_last;
   logic                  m1, m2, md;
   assign oitf_empty = (alloc_ptr == ret_ptr) & (alloc_flg == ret_flg);
   assign full       = (alloc_ptr == ret_ptr) & (alloc_flg != ret_flg);
   assign ret_fire   = oitf_ret_ena & ~oitf_empty;
`ifdef OITF_FULL_BYPASS_EN
   assign dis_ready  = ~full | ret_fire;
`else
   assign dis_ready  = ~full;
`endif
   assign alloc_fire = dis_ena & dis_ready;
   assign alloc_last = alloc_ptr == AW'(OITF_DEPTH - 1);
   assign ret_last   = ret_ptr == AW'(OITF_DEPTH - 1);
   assign dis_ptr        = alloc_ptr;
   assign oitf_ret_ptr   = ret_ptr;
   assign oitf_ret_rdwen = rdwen[ret_ptr];
   assign oitf_ret_rdidx = rdidx[ret_ptr];
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         alloc_ptr <= '0;
         alloc_flg <= 1'b0;
         ret_ptr   <= '0;
         ret_flg   <= 1'b0;
      end else begin
         if (alloc_fire) begin
            alloc_ptr <= alloc_last ? '0 : alloc_ptr + 1'b1;
            alloc_flg <= alloc_flg ^ alloc_last;
         end
         if (ret_fire) begin
            ret_ptr <= ret_last ? '0 : ret_ptr + 1'b1;
            ret_flg <= ret_flg ^ ret_last;
         end
      end
   end
   // Allocation wins on a shared slot: only the full-bypass case can alias
   // alloc_ptr with ret_ptr, and there the new instruction takes the slot.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld   <= '0;
         rdwen <= '0;
         for (int i = 0; i < OITF_DEPTH; i++) rdidx[i] <= '0;
      end else begin
         for (int i = 0; i < OITF_DEPTH; i++) begin
            if (alloc_fire && alloc_ptr == AW'(i)) begin
               vld[i]   <= 1'b1;
               rdwen[i] <= dis_rdwen;
               rdidx[i] <= dis_rdidx;
            end else if (ret_fire && ret_ptr == AW'(i)) begin
               vld[i] <= 1'b0;
            end
         end
      end
   end
   // Hazards look only at registered entries; a same-cycle allocation is not seen.
   always_comb begin
      m1 = 1'b0;
      m2 = 1'b0;
      md = 1'b0;
      for (int i = 0; i < OITF_DEPTH; i++) begin
         m1 = m1 | (vld[i] & rdwen[i] & (rdidx[i] == disp_rs1idx));
         m2 = m2 | (vld[i] & rdwen[i] & (rdidx[i] == disp_rs2idx));
         md = md | (vld[i] & rdwen[i] & (rdidx[i] == dis_rdidx));
      end
   end
   assign oitfrd_match_rs1 = m1 & disp_rs1en;
   assign oitfrd_match_rs2 = m2 & disp_rs2en;
   assign oitfrd_match_rd  = md & dis_rdwen;
endmodule

// File: tb/tb_exu_oitf.sv
// tb_exu_oitf: directed self-checking bench for exu_oitf
`ifndef ITAG_WIDTH
`define ITAG_WIDTH 2
`endif
`ifndef RFIDX_WIDTH
`define RFIDX_WIDTH 5
`endif
module tb_exu_oitf;
   logic clk = 1'b0, rst = 1'b1;
   logic dis_ena = 0, dis_rdwen = 0, disp_rs1en = 0, disp_rs2en = 0, oitf_ret_ena = 0;
   logic [`RFIDX_WIDTH-1:0] dis_rdidx = '0, disp_rs1idx = '0, disp_rs2idx = '0;
   logic dis_ready, oitfrd_match_rs1, oitfrd_match_rs2, oitfrd_match_rd, oitf_ret_rdwen, oitf_empty;
   logic [`ITAG_WIDTH-1:0] dis_ptr, oitf_ret_ptr;
   logic [`RFIDX_WIDTH-1:0] oitf_ret_rdidx;
   int checks = 0, failures = 0;
   exu_oitf #(.OITF_DEPTH(4)) dut (
      .clk(clk), .rst(rst), .dis_ena(dis_ena), .dis_ready(dis_ready),
      .dis_rdwen(dis_rdwen), .dis_rdidx(dis_rdidx), .dis_ptr(dis_ptr),
      .disp_rs1idx(disp_rs1idx), .disp_rs2idx(disp_rs2idx),
      .disp_rs1en(disp_rs1en), .disp_rs2en(disp_rs2en),
      .oitfrd_match_rs1(oitfrd_match_rs1), .oitfrd_match_rs2(oitfrd_match_rs2),
      .oitfrd_match_rd(oitfrd_match_rd), .oitf_ret_ena(oitf_ret_ena),
      .oitf_ret_ptr(oitf_ret_ptr), .oitf_ret_rdwen(oitf_ret_rdwen),
      .oitf_ret_rdidx(oitf_ret_rdidx), .oitf_empty(oitf_empty)
   );
   always #5 clk = ~clk;
   task automatic step;
      @(posedge clk);
      #1;
   endtask
   task automatic test_reset;
      rst = 1'b1;
      #1;
      checks++; if (oitf_empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", oitf_empty); end
      checks++; if (dis_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", dis_ready); end
      checks++; if (dis_ptr !== 2'd0 || oitf_ret_ptr !== 2'd0) begin failures++; $display("FAIL reset_ptrs got=%0d/%0d exp=0/0", dis_ptr, oitf_ret_ptr); end
      step();
      rst = 1'b0;
      step();
   endtask
   task automatic test_alloc_full;
      dis_ena = 1'b1;
      dis_rdwen = 1'b1;
      for (int k = 0; k < 4; k++) begin
         dis_rdidx = 5'(k + 1);
         #1;
         checks++; if (dis_ptr !== 2'(k)) begin failures++; $display("FAIL alloc_ptr%0d got=%0d exp=%0d", k, dis_ptr, k); end
         checks++; if (dis_ready !== 1'b1) begin failures++; $display("FAIL alloc_ready%0d got=%b exp=1", k, dis_ready); end
         step();
      end
      dis_ena = 1'b0;
      #1;
      checks++; if (dis_ready !== 1'b0) begin failures++; $display("FAIL full_ready got=%b exp=0", dis_ready); end
      checks++; if (oitf_ret_rdidx !== 5'd1 || oitf_ret_ptr !== 2'd0) begin failures++; $display("FAIL full_oldest got=%0d@%0d exp=1@0", oitf_ret_rdidx, oitf_ret_ptr); end
      checks++; if (oitf_empty !== 1'b0 || oitf_ret_rdwen !== 1'b1) begin failures++; $display("FAIL full_state empty=%b rdwen=%b exp=0/1", oitf_empty, oitf_ret_rdwen); end
   endtask
   task automatic test_retire;
      for (int k = 0; k < 4; k++) begin
         checks++; if (oitf_ret_rdidx !== 5'(k + 1) || oitf_ret_ptr !== 2'(k)) begin failures++; $display("FAIL ret_order%0d got=%0d@%0d exp=%0d@%0d", k, oitf_ret_rdidx, oitf_ret_ptr, k + 1, k); end
         oitf_ret_ena = 1'b1;
         step();
      end
      oitf_ret_ena = 1'b0;
      #1;
      checks++; if (oitf_empty !== 1'b1 || dis_ready !== 1'b1) begin failures++; $display("FAIL drained empty=%b ready=%b exp=1/1", oitf_empty, dis_ready); end
      oitf_ret_ena = 1'b1;
      step();
      oitf_ret_ena = 1'b0;
      #1;
      checks++; if (oitf_ret_ptr !== 2'd0 || dis_ptr !== 2'd0 || oitf_empty !== 1'b1) begin failures++; $display("FAIL ret_on_empty ret=%0d alloc=%0d empty=%b exp=0/0/1", oitf_ret_ptr, dis_ptr, oitf_empty); end
   endtask
   task automatic test_back_to_back;
      dis_ena = 1'b1;
      dis_rdwen = 1'b1;
      dis_rdidx = 5'd10; step();
      dis_rdidx = 5'd11; step();
      oitf_ret_ena = 1'b1;
      for (int c = 0; c < 10; c++) begin
         dis_rdidx = 5'(12 + c);
         #1;
         checks++; if (dis_ptr !== 2'((2 + c) % 4) || oitf_ret_ptr !== 2'(c % 4)) begin failures++; $display("FAIL b2b_ptr%0d got=%0d/%0d exp=%0d/%0d", c, dis_ptr, oitf_ret_ptr, (2 + c) % 4, c % 4); end
         checks++; if (oitf_ret_rdidx !== 5'(10 + c)) begin failures++; $display("FAIL b2b_rdidx%0d got=%0d exp=%0d", c, oitf_ret_rdidx, 10 + c); end
         step();
      end
      dis_ena = 1'b0;
      #1;
      checks++; if (oitf_empty !== 1'b0 || dis_ready !== 1'b1 || dis_ptr !== 2'd0 || oitf_ret_ptr !== 2'd2) begin failures++; $display("FAIL b2b_end empty=%b ready=%b ptrs=%0d/%0d exp=0/1/0/2", oitf_empty, dis_ready, dis_ptr, oitf_ret_ptr); end
      for (int k = 0; k < 2; k++) begin
         checks++; if (oitf_ret_rdidx !== 5'(20 + k)) begin failures++; $display("FAIL b2b_drain%0d got=%0d exp=%0d", k, oitf_ret_rdidx, 20 + k); end
         step();
      end
      oitf_ret_ena = 1'b0;
      #1;
      checks++; if (oitf_empty !== 1'b1) begin failures++; $display("FAIL b2b_empty got=%b exp=1", oitf_empty); end
   endtask
   task automatic test_hazard;
      dis_ena = 1'b1; dis_rdwen = 1'b1; dis_rdidx = 5'd5;
      disp_rs1idx = 5'd5; disp_rs1en = 1'b1;
      #1;
      checks++; if (oitfrd_match_rs1 !== 1'b0) begin failures++; $display("FAIL haz_same_cycle got=%b exp=0", oitfrd_match_rs1); end
      step();
      dis_ena = 1'b0;
      disp_rs2idx = 5'd5; disp_rs2en = 1'b1;
      #1;
      checks++; if (oitfrd_match_rs1 !== 1'b1 || oitfrd_match_rs2 !== 1'b1 || oitfrd_match_rd !== 1'b1) begin failures++; $display("FAIL haz_hit got=%b%b%b exp=111", oitfrd_match_rs1, oitfrd_match_rs2, oitfrd_match_rd); end
      disp_rs1en = 1'b0; disp_rs2idx = 5'd6; dis_rdwen = 1'b0;
      #1;
      checks++; if (oitfrd_match_rs1 !== 1'b0 || oitfrd_match_rs2 !== 1'b0 || oitfrd_match_rd !== 1'b0) begin failures++; $display("FAIL haz_off got=%b%b%b exp=000", oitfrd_match_rs1, oitfrd_match_rs2, oitfrd_match_rd); end
      disp_rs1en = 1'b1;
      oitf_ret_ena = 1'b1;
      step();
      oitf_ret_ena = 1'b0;
      #1;
      checks++; if (oitfrd_match_rs1 !== 1'b0) begin failures++; $display("FAIL haz_retired got=%b exp=0", oitfrd_match_rs1); end
      dis_ena = 1'b1; dis_rdwen = 1'b0; dis_rdidx = 5'd5;
      step();
      dis_ena = 1'b0;
      #1;
      checks++; if (oitfrd_match_rs1 !== 1'b0 || oitf_empty !== 1'b0) begin failures++; $display("FAIL haz_nowen match=%b empty=%b exp=0/0", oitfrd_match_rs1, oitf_empty); end
      oitf_ret_ena = 1'b1;
      step();
      oitf_ret_ena = 1'b0;
      disp_rs1en = 1'b0; disp_rs2en = 1'b0;
      #1;
      checks++; if (oitf_empty !== 1'b1) begin failures++; $display("FAIL haz_empty got=%b exp=1", oitf_empty); end
   endtask
   task automatic test_full_simul;
      dis_ena = 1'b1; dis_rdwen = 1'b1;
      for (int k = 0; k < 4; k++) begin
         dis_rdidx = 5'(k + 1);
         step();
      end
      dis_rdidx = 5'd9;
      oitf_ret_ena = 1'b1;
      #1;
`ifdef OITF_FULL_BYPASS_EN
      checks++; if (dis_ready !== 1'b1) begin failures++; $display("FAIL simul_ready got=%b exp=1", dis_ready); end
`else
      checks++; if (dis_ready !== 1'b0) begin failures++; $display("FAIL simul_ready got=%b exp=0", dis_ready); end
`endif
      step();
      dis_ena = 1'b0; oitf_ret_ena = 1'b0;
      #1;
`ifdef OITF_FULL_BYPASS_EN
      checks++; if (dis_ready !== 1'b0 || oitf_ret_rdidx !== 5'd2) begin failures++; $display("FAIL simul_after ready=%b rdidx=%0d exp=0/2", dis_ready, oitf_ret_rdidx); end
`else
      checks++; if (dis_ready !== 1'b1 || oitf_ret_rdidx !== 5'd2) begin failures++; $display("FAIL simul_after ready=%b rdidx=%0d exp=1/2", dis_ready, oitf_ret_rdidx); end
`endif
   endtask
   task automatic test_async_reset;
      while (!oitf_empty && oitf_ret_rdidx != 5'd3) begin
         oitf_ret_ena = 1'b1;
         step();
      end
      oitf_ret_ena = 1'b0;
      disp_rs1idx = 5'd3; disp_rs1en = 1'b1;
      #1;
      checks++; if (oitfrd_match_rs1 !== 1'b1 || oitf_ret_rdidx !== 5'd3) begin failures++; $display("FAIL pre_rst match=%b rdidx=%0d exp=1/3", oitfrd_match_rs1, oitf_ret_rdidx); end
      dis_ena = 1'b1; oitf_ret_ena = 1'b1; dis_rdidx = 5'd7;
      #1;
      rst = 1'b1;
      #1;
      checks++; if (oitf_empty !== 1'b1 || dis_ready !== 1'b1 || dis_ptr !== 2'd0 || oitf_ret_ptr !== 2'd0) begin failures++; $display("FAIL async_rst empty=%b ready=%b ptrs=%0d/%0d exp=1/1/0/0", oitf_empty, dis_ready, dis_ptr, oitf_ret_ptr); end
      checks++; if (oitf_ret_rdwen !== 1'b0 || oitf_ret_rdidx !== 5'd0 || oitfrd_match_rs1 !== 1'b0) begin failures++; $display("FAIL async_rst_fields rdwen=%b rdidx=%0d match=%b exp=0/0/0", oitf_ret_rdwen, oitf_ret_rdidx, oitfrd_match_rs1); end
      step();
      dis_ena = 1'b0; oitf_ret_ena = 1'b0; rst = 1'b0;
      #1;
      checks++; if (oitf_empty !== 1'b1 || dis_ptr !== 2'd0) begin failures++; $display("FAIL rst_discard empty=%b ptr=%0d exp=1/0", oitf_empty, dis_ptr); end
   endtask
   initial begin
      test_reset();
      test_alloc_full();
      test_retire();
      test_back_to_back();
      test_hazard();
      test_full_simul();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
